real_pair_feeder: RTL and testbench

- Upstream operand sequencer and result collector for the registered 64-bit real adder stage (real_adder; blackbox FP add followed by an output register).
- Accepts a valid/ready stream of IEEE-754 doubles, pairs consecutive words into operands a1/a2, and issues each pair to the adder.
- Tracks adder latency with a tag pipeline and captures each sum into a small result FIFO with valid/ready output.
- Credit-limited so a result never lands in a full FIFO.

---
 rtl/real_pair_feeder.sv | 189 ++++++++++++++++++
 tb/tb_real_pair_feeder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/real_pair_feeder.sv
`timescale 1ns/1ps
// real_pair_feeder
//   Sits in front of a registered 64-bit real adder. Pairs consecutive
//   words from an input stream into adder operands, follows each issued pair
//   through the adder with a tag pipeline, and collects the sums in a small
//   first-word fall-through FIFO. Issue is limited by credits, so a sum
//   never arrives at a full FIFO.
//
//   Ports
//     clk, reset          rising-edge clock, synchronous active-high reset
//     in_valid/in_ready   input word handshake, in_data carries the double
//     in_last             (REAL_PAIR_FLUSH_EN only) marks the final word
//     add_a1, add_a2      registered operands to the adder
//     add_c               adder result
//     out_valid/out_ready result handshake, out_data is the FIFO head
//     busy                held operand, sum in flight, or FIFO not empty
//
//   Build option: define REAL_PAIR_FLUSH_EN to add in_last and the PAD
//   state. A trailing odd word is then issued paired with +0.0.
//
//   state | meaning
//   EMPTY | no operand held, ready for the first word of a pair
//   HOLD  | first word held, the next accepted word issues the pair
//   PAD   | final odd word held, issues with +0.0 once credit allows

module real_pair_feeder #(
  parameter int WIDTH       = 64,
  parameter int ADD_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef REAL_PAIR_FLUSH_EN
  input  logic             in_last,
`endif
  output logic [WIDTH-1:0] add_a1,
  output logic [WIDTH-1:0] add_a2,
  input  logic [WIDTH-1:0] add_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = ADD_LATENCY + 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1
`ifdef REAL_PAIR_FLUSH_EN
    ,
    ST_PAD   = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] a1_q, a1_d;
  logic [WIDTH-1:0] a2_q, a2_d;
  logic [TW-1:0]    tag_q, tag_d;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic             issue;
  logic             credit_ok;
  logic             push;
  logic             pop;
  logic [31:0]      inflight;

  // Credit counts FIFO entries plus every tag still in the pipe, all from
  // registered state, so a pop this cycle only frees a slot next cycle.
  always_comb begin
    inflight = 32'd0;
    for (int i = 0; i < TW; i++) begin
      inflight = inflight + 32'(tag_q[i]);
    end
    credit_ok = (32'(count_q) + inflight) < 32'(FIFO_DEPTH);
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    a1_d     = a1_q;
    a2_d     = a2_q;
    issue    = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hold_d  = in_data;
          state_d = ST_HOLD;
`ifdef REAL_PAIR_FLUSH_EN
          if (in_last) state_d = ST_PAD;
`endif
        end
      end
      ST_HOLD: begin
        in_ready = credit_ok;
        if (in_valid && credit_ok) begin
          a1_d    = hold_q;
          a2_d    = in_data;
          issue   = 1'b1;
          state_d = ST_EMPTY;
        end
      end
`ifdef REAL_PAIR_FLUSH_EN
      ST_PAD: begin
        if (credit_ok) begin
          a1_d    = hold_q;
          a2_d    = '0;
          issue   = 1'b1;
          state_d = ST_EMPTY;
        end
      end
`endif
      default: state_d = ST_EMPTY;
    endcase
  end

  // The last tag stage lines up with the cycle add_c holds this pair's sum.
  assign push      = tag_q[TW-1];
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    tag_d    = {tag_q[TW-2:0], issue};
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = add_c;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      hold_q   <= '0;
      a1_q     <= '0;
      a2_q     <= '0;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign add_a1   = a1_q;
  assign add_a2   = a2_q;
  assign out_data = mem_q[rd_ptr_q];
  assign busy     = (state_q != ST_EMPTY) || (inflight != 32'd0) || out_valid;

  // Credits make this unreachable; firing means the credit count is broken.
  push_not_full: assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_real_pair_feeder.sv
`timescale 1ns/1ps
module tb_real_pair_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
`ifdef REAL_PAIR_FLUSH_EN
  logic        in_last = 1'b0;
`endif
  logic [63:0] add_a1, add_a2;
  logic [63:0] add_c = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        busy;

  int          n_tests = 0;
  int          n_fail = 0;
  int          n_push = 0;
  int          n_pop = 0;
  int          stall_cnt = 0;
  logic [63:0] exp_q[$];
  bit          have_first = 0;
  logic [63:0] first_w = '0;

  real_pair_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef REAL_PAIR_FLUSH_EN
    .in_last   (in_last),
`endif
    .add_a1    (add_a1),
    .add_a2    (add_a2),
    .add_c     (add_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Registered real adder, not reset.
  always @(posedge clk)
    add_c <= $realtobits($bitstoreal(add_a1) + $bitstoreal(add_a2));

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dbl(input int v);
    return $realtobits(real'(v));
  endfunction

  task automatic sb_accept(input logic [63:0] d, input bit last);
    if (have_first) begin
      exp_q.push_back($realtobits($bitstoreal(first_w) + $bitstoreal(d)));
      n_push++;
      have_first = 0;
    end else if (last) begin
      exp_q.push_back($realtobits($bitstoreal(d) + 0.0));
      n_push++;
    end else begin
      first_w    = d;
      have_first = 1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [63:0] d, input bit last, input int budget);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
`ifdef REAL_PAIR_FLUSH_EN
    in_last  = last;
`endif
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb_accept(d, last);
        break;
      end
      waited++;
      stall_cnt++;
      if (waited > budget) begin
        check_val("send_timeout", 64'(waited), 64'(budget));
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
`ifdef REAL_PAIR_FLUSH_EN
    in_last  = 1'b0;
`endif
  endtask

  task automatic drain(input int budget);
    int n = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
      n++;
      if (n > budget) begin
        check_val("drain_timeout", 64'(n), 64'(budget));
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a pop happens on the next edge whenever valid & ready here.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      check_val("sb_has_entry", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        check_val("sb_data", out_data, exp_q.pop_front());
        n_pop++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    @(negedge clk);
    check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_val("rst_a1", add_a1, 64'd0);
    check_val("rst_a2", add_a2, 64'd0);
    @(posedge clk);
    #1;

    // single pair: 1.0 + 2.0
    send(64'h3FF0000000000000, 0, 10);
    send(64'h4000000000000000, 0, 10);
    @(negedge clk);
    check_val("pair_a1", add_a1, 64'h3FF0000000000000);
    check_val("pair_a2", add_a2, 64'h4000000000000000);
    check_val("pair_ov_k", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check_val("pair_ov_k1", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check_val("pair_ov_k2", {63'd0, out_valid}, 64'd1);
    check_val("pair_sum", out_data, 64'h4008000000000000);
    @(posedge clk);
    #1;
    drain(20);

    // streaming with the consumer always ready
    stall_cnt = 0;
    for (int i = 0; i < 8; i++) send(dbl(10 + i), 0, 10);
    @(negedge clk);
    check_val("strm_busy_k", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check_val("strm_busy_k1", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check_val("strm_busy_k2", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check_val("strm_busy_k3", {63'd0, busy}, 64'd0);
    check_val("strm_stalls", 64'(stall_cnt), 64'd0);
    check_val("strm_sb_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // backpressure: FIFO fills, ninth word held, tenth stalls
    out_ready = 1'b0;
    stall_cnt = 0;
    for (int i = 0; i < 9; i++) send(dbl(20 + i), 0, 10);
    check_val("bp_first9_stalls", 64'(stall_cnt), 64'd0);
    in_valid = 1'b1;
    in_data  = dbl(29);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (in_ready) seen = 1;
    end
    check_val("bp_ready_seen", {63'd0, seen}, 64'd0);
    check_val("bp_out_valid", {63'd0, out_valid}, 64'd1);
    check_val("bp_busy", {63'd0, busy}, 64'd1);
    check_val("bp_count", 64'(dut.count_q), 64'd4);
    check_val("bp_sb_depth", 64'(exp_q.size()), 64'd4);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(dbl(29), 0, 10);
    send(dbl(30), 0, 10);
    send(dbl(31), 0, 10);
    drain(40);

    // same-cycle push and pop with three entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(dbl(40 + i), 0, 10);
    repeat (4) @(posedge clk);
    #1;
    send(dbl(46), 0, 10);
    send(dbl(47), 0, 10);
    @(negedge clk);
    check_val("pp_count_k", 64'(dut.count_q), 64'd3);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check_val("pp_count_k1", 64'(dut.count_q), 64'd3);
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check_val("pp_count_k2", 64'(dut.count_q), 64'd3);
    @(posedge clk);
    #1;
    drain(40);

    // odd word stays held until a partner arrives
    send(dbl(100), 0, 10);
    repeat (5) @(negedge clk);
    check_val("odd_busy", {63'd0, busy}, 64'd1);
    check_val("odd_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("odd_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // reset the cycle after an issue: the sum must never appear
    out_ready = 1'b1;
    send(dbl(101), 0, 10);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    n_push = n_push - exp_q.size();
    exp_q.delete();
    have_first = 0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check_val("rmf_out_seen", {63'd0, seen}, 64'd0);
    check_val("rmf_busy", {63'd0, busy}, 64'd0);
    check_val("rmf_a1", add_a1, 64'd0);
    check_val("rmf_a2", add_a2, 64'd0);
    check_val("rmf_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

`ifdef REAL_PAIR_FLUSH_EN
    // lone last word issues padded with +0.0
    out_ready = 1'b0;
    send(64'h4008000000000000, 1, 10);
    @(negedge clk);
    check_val("pad_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    check_val("pad_a1", add_a1, 64'h4008000000000000);
    check_val("pad_a2", add_a2, 64'd0);
    @(negedge clk);
    check_val("pad_ov_1", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check_val("pad_ov_2", {63'd0, out_valid}, 64'd1);
    check_val("pad_sum", out_data, 64'h4008000000000000);
    @(posedge clk);
    #1;
    drain(20);
`endif

    check_val("sb_pop_count", 64'(n_pop), 64'(n_push));
    check_val("sb_final_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
